// File: rtl/d_sr_driver_pkg.sv
// ff_conv_pkg: shared definitions for the D-to-SR conversion driver.
//   DEFAULT_WIDTH : default number of data bits / SR flip-flops in the bank
//   state_t       : controller states (IDLE, EXCITE, DONE)
package ff_conv_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXCITE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/d_sr_driver_if.sv
// d_sr_driver_if: word handshake into the D-to-SR driver.
//   in_valid : d carries a new target word
//   in_ready : driver accepts a word this cycle
//   d        : target word for the SR bank
// master drives in_valid/d, slave (the driver) returns in_ready.
interface d_sr_driver_if #(
    parameter int WIDTH = 8
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d;

    modport master (output in_valid, output d, input in_ready);
    modport slave  (input in_valid, input d, output in_ready);

endinterface

// File: rtl/d_sr_driver_sr_ff.sv
// sr_ff: one SR flip-flop of the bank.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset, q -> 0
//   s, r  : set / reset excitation
//   q     : stored bit
// S=R=1 is never produced by the driver; it holds here so a glitch cannot
// pick an arbitrary value.
module sr_ff (
    input  logic clk,
    input  logic reset,
    input  logic s,
    input  logic r,
    output logic q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 1'b0;
        end else if (s && !r) begin
            q <= 1'b1;
        end else if (r && !s) begin
            q <= 1'b0;
        end
    end

endmodule

// File: rtl/d_sr_driver.sv
// d_sr_driver: converts an accepted D target word into a bit-serial sequence
// of SR excitations that walks a bank of WIDTH sr_ff cells to the target.
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset
//   bus     : slave side of d_sr_driver_if (in_valid, in_ready, d)
//   s, r    : set / reset excitation driven into the bank this cycle
//   q       : SR bank state
//   busy    : high in EXCITE and DONE
//   done    : one-cycle pulse once q equals the accepted target
//   chg_cnt : bits changed in the last transaction (only with CHG_CNT_EN)
// Optional feature macro: CHG_CNT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | in_ready=1, waiting for a target word
// ST_EXCITE | one bit per cycle, index 0..WIDTH-1, exciting only that bit
// ST_DONE   | single cycle, done pulse, back to IDLE
module d_sr_driver
    import ff_conv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    d_sr_driver_if.slave               bus,
    output logic [WIDTH-1:0]           s,
    output logic [WIDTH-1:0]           r,
    output logic [WIDTH-1:0]           q,
    output logic                       busy,
    output logic                       done
`ifdef CHG_CNT_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] chg_cnt
`endif
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q;
    logic [IDX_W-1:0] idx_q;
    logic             accept;
    logic             last_bit;

    assign accept   = (state_q == ST_IDLE) && bus.in_valid;
    assign last_bit = (idx_q == IDX_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bus.in_ready = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        s            = '0;
        r            = '0;
        case (state_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = ST_EXCITE;
                end
            end
            ST_EXCITE: begin
                busy = 1'b1;
                // Only the indexed bit is excited; the two terms are mutually
                // exclusive, so S=R=1 cannot reach the bank.
                s[idx_q] = target_q[idx_q] & ~q[idx_q];
                r[idx_q] = ~target_q[idx_q] & q[idx_q];
                if (last_bit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            target_q <= '0;
            idx_q    <= '0;
        end else if (accept) begin
            target_q <= bus.d;
            idx_q    <= '0;
        end else if ((state_q == ST_EXCITE) && !last_bit) begin
            idx_q <= idx_q + IDX_W'(1);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bank
        sr_ff u_ff (
            .clk   (clk),
            .reset (reset),
            .s     (s[i]),
            .r     (r[i]),
            .q     (q[i])
        );
    end

`ifdef CHG_CNT_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] chg_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chg_q <= '0;
        end else if (accept) begin
            chg_q <= '0;
        end else if ((state_q == ST_EXCITE) && ((s | r) != '0)) begin
            chg_q <= chg_q + CNT_W'(1);
        end
    end

    assign chg_cnt = chg_q;
`endif

endmodule

// File: tb/tb_d_sr_driver.sv
module tb_d_sr_driver;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic [W-1:0] q;
    logic         busy;
    logic         done;
`ifdef CHG_CNT_EN
    logic [3:0]   chg_cnt;
`endif

    d_sr_driver_if #(.WIDTH(W)) bus ();

    d_sr_driver #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .s       (s),
        .r       (r),
        .q       (q),
        .busy    (busy),
        .done    (done)
`ifdef CHG_CNT_EN
        ,
        .chg_cnt (chg_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] r;
        logic [W-1:0] q;
        logic         done;
        int           cnt;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] model_q;
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle bank excitation for moving model_q to t, then the DONE cycle.
    task automatic push_txn(input logic [W-1:0] t);
        logic [W-1:0] mq;
        exp_t         e;
        int           cnt;
        mq  = model_q;
        cnt = 0;
        for (int k = 0; k < W; k++) begin
            e.s    = '0;
            e.r    = '0;
            e.s[k] = t[k] & ~mq[k];
            e.r[k] = ~t[k] & mq[k];
            e.q    = mq;
            e.done = 1'b0;
            e.cnt  = 0;
            if (t[k] != mq[k]) cnt++;
            sb.push_back(e);
            mq[k] = t[k];
        end
        e.s    = '0;
        e.r    = '0;
        e.q    = t;
        e.done = 1'b1;
        e.cnt  = cnt;
        sb.push_back(e);
        model_q = t;
    endtask

    task automatic run_txn(input logic [W-1:0] t, input bit stress, input int abort_at);
        exp_t e;
        int   cyc;
        check($sformatf("ready_before_%0h", t), {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.d        = t;
        push_txn(t);
        step();
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (stress && !e.done) begin
                bus.in_valid = 1'b1;
                bus.d        = W'($urandom);
            end else begin
                bus.in_valid = 1'b0;
            end
            if (cyc == abort_at) begin
                reset = 1'b0;
                #1;
                check("rst_q",     q, 0);
                check("rst_s",     s, 0);
                check("rst_r",     r, 0);
                check("rst_busy",  {31'd0, busy}, 0);
                check("rst_done",  {31'd0, done}, 0);
                check("rst_ready", {31'd0, bus.in_ready}, 1);
`ifdef CHG_CNT_EN
                check("rst_chg", chg_cnt, 0);
`endif
                sb.delete();
                model_q = '0;
                #2;
                reset = 1'b1;
                return;
            end
            check($sformatf("s_%0h_c%0d", t, cyc), s, e.s);
            check($sformatf("r_%0h_c%0d", t, cyc), r, e.r);
            check($sformatf("q_%0h_c%0d", t, cyc), q, e.q);
            check($sformatf("sr_%0h_c%0d", t, cyc), s & r, 0);
            check($sformatf("done_%0h_c%0d", t, cyc), {31'd0, done}, {31'd0, e.done});
            check($sformatf("busy_%0h_c%0d", t, cyc), {31'd0, busy}, 1);
            check($sformatf("ready_%0h_c%0d", t, cyc), {31'd0, bus.in_ready}, 0);
`ifdef CHG_CNT_EN
            if (e.done) check($sformatf("chg_%0h", t), chg_cnt, e.cnt);
`endif
            step();
            cyc++;
        end
        check($sformatf("done_after_%0h", t), {31'd0, done}, 0);
        check($sformatf("busy_after_%0h", t), {31'd0, busy}, 0);
        check($sformatf("q_after_%0h", t), q, t);
    endtask

    initial begin
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.d        = '0;
        model_q      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_q",     q, 0);
        check("reset_s",     s, 0);
        check("reset_r",     r, 0);
        check("reset_busy",  {31'd0, busy}, 0);
        check("reset_done",  {31'd0, done}, 0);
        check("reset_ready", {31'd0, bus.in_ready}, 1);
        reset = 1'b1;

        run_txn(8'hA5, 1'b0, -1);
        run_txn(8'h5A, 1'b0, -1);
        run_txn(8'h5A, 1'b0, -1);
        run_txn(8'h3C, 1'b1, -1);
        run_txn(8'hFF, 1'b0, 3);
        run_txn(8'h01, 1'b0, -1);
        for (int i = 0; i < 4; i++) begin
            run_txn(W'($urandom), i[0], -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
